uart_rx_frame: RTL

- 8N1 UART receiver; the counterpart of the team's TX path (bps_tx + uart_tx).
- Synchronises the serial line and detects the falling edge of the start bit.
- Generates its own bit timing, majority-samples each bit at mid-period and assembles the byte LSB-first.
- Delivers each byte with a one-cycle valid strobe plus frame-error status, for downstream command parsing.

---
 rtl/uart_rx_frame.sv | 85 ++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with 3-sample majority vote and frame-error status
module uart_rx_frame #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int BIT_CNT  = CLK_FREQ / BAUD,
    parameter int MID      = BIT_CNT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int CW = $clog2(BIT_CNT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, nxt;
    logic          s1, s2, h;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [1:0]    smp;
    logic [7:0]    sh, data_q;
    logic          ferr_q;
    logic          start_edge, wrap, res, maj;

    assign start_edge = h & ~s2;
    assign wrap       = cnt == CW'(BIT_CNT - 1);
    assign res        = cnt == CW'(MID + 1);
    assign maj        = (smp[1] & smp[0]) | (smp[1] & s2) | (smp[0] & s2);
    assign rx_busy    = state != IDLE;
    // The strobe and its status are driven while the stop bit is resolved, so the byte is valid in the strobe cycle
    assign rx_done    = (state == STOP) & res;
    assign rx_data    = rx_done ? sh : data_q;
    assign frame_err  = rx_done ? ~maj : ferr_q;

    // Two-flop synchroniser plus history flop; idle-high reset avoids a false start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {s1, s2, h} <= 3'b111;
        else      {s1, s2, h} <= {data_in, s1, s2};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // Next state: glitch abort in START, bit index walk in DATA, leave STOP at mid-bit
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start_edge ? START : IDLE;
            START:   nxt = (res && maj) ? IDLE : (wrap ? DATA : START);
            DATA:    nxt = (wrap && idx == 3'd7) ? STOP : DATA;
            STOP:    nxt = res ? IDLE : STOP;
            default: nxt = IDLE;
        endcase
    end

    // Bit timing, sampling, byte assembly and held output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            idx    <= '0;
            smp    <= '0;
            sh     <= '0;
            data_q <= '0;
            ferr_q <= 1'b0;
        end else begin
            cnt <= (state == IDLE || nxt == IDLE || wrap) ? '0 : cnt + 1'b1;
            if (cnt == CW'(MID - 1)) smp[1] <= s2;
            if (cnt == CW'(MID)) smp[0] <= s2;
            if (state == START) idx <= '0;
            if (state == DATA && res) sh[idx] <= maj;
            if (state == DATA && wrap) idx <= idx + 1'b1;
            if (rx_done) begin
                data_q <= sh;
                ferr_q <= ~maj;
            end
        end
    end
endmodule
